// File: rtl/rr_merge_ctrl.sv
// rr_merge_ctrl: P-way round-robin merge controller for 4-phase bundled-data
// channels. One requester at a time is granted. Its data is latched, and the
// full handshake is sequenced on both the requester side and the shared
// consumer side.
//
// Ports
//   clk   in   1     clock, all state updates on the rising edge
//   rst   in   1     asynchronous reset, active-high
//   r_i   in   P     request per requester (4-phase)
//   a_i   out  P     acknowledge per requester (one-hot or zero)
//   d_i   in   P*N   data, requester k at d_i[k*N +: N]
//   r_o   out  1     request to the shared consumer
//   a_o   in   1     acknowledge from the shared consumer
//   d_o   out  N     latched data of the granted requester
//   g_o   out  GW    index of the current or last granted requester
//   busy  out  1     high in any state other than IDLE
module rr_merge_ctrl #(
  parameter  int unsigned N  = 8,
  parameter  int unsigned P  = 4,
  localparam int unsigned GW = $clog2(P)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [P-1:0]    r_i,
  output logic [P-1:0]    a_i,
  input  logic [P*N-1:0]  d_i,
  output logic            r_o,
  input  logic            a_o,
  output logic [N-1:0]    d_o,
  output logic [GW-1:0]   g_o,
  output logic            busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_RTZ  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   ptr_q,   ptr_d;
  logic [GW-1:0]   g_q,     g_d;
  logic [N-1:0]    dat_q,   dat_d;

  logic [N-1:0]    d_arr [P];
  logic [GW-1:0]   win;
  logic            win_vld;

  // Split the flat data bus into one word per requester.
  for (genvar k = 0; k < P; k++) begin : g_split
    assign d_arr[k] = d_i[k*N +: N];
  end

  // Round-robin search. It starts one past the last winner and wraps at P-1.
  // A modulo is used so that a non-power-of-two P never selects an index >= P.
  always_comb begin
    int unsigned cand;
    win     = '0;
    win_vld = 1'b0;
    cand    = 0;
    for (int unsigned i = 1; i <= P; i++) begin
      cand = (32'(ptr_q) + i) % P;
      if (!win_vld && r_i[GW'(cand)]) begin
        win     = GW'(cand);
        win_vld = 1'b1;
      end
    end
  end

  // State register and the grant, pointer and data registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= GW'(P - 1);
      g_q     <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      g_q     <= g_d;
      dat_q   <= dat_d;
    end
  end

  // Next-state logic. The pointer advances only once the consumer has
  // returned to zero, so the whole transfer completes before rotation.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    g_d     = g_q;
    dat_d   = dat_q;
    unique case (state_q)
      S_IDLE: begin
        // A stale consumer ack blocks new grants until it drops.
        if (win_vld && !a_o) begin
          g_d     = win;
          dat_d   = d_arr[win];
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        // A requester that withdraws early is ignored here. The consumer
        // handshake still completes, and HOLD then exits straight away.
        if (a_o) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (!r_i[g_q]) state_d = S_RTZ;
      end
      S_RTZ: begin
        if (!a_o) begin
          ptr_d   = g_q;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs, decoded only from registered state.
  always_comb begin
    r_o  = 1'b0;
    a_i  = '0;
    busy = (state_q != S_IDLE);
    d_o  = dat_q;
    g_o  = g_q;
    unique case (state_q)
      S_REQ:   r_o = 1'b1;
      S_HOLD: begin
        r_o      = 1'b1;
        a_i[g_q] = 1'b1;
      end
      S_RTZ:   a_i[g_q] = 1'b1;
      default: ;
    endcase
  end

endmodule
